// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared camera-config definitions: ROM word layout, table control codes and sequencer states.
package cam_cfg_sequencer_pkg;

    localparam int unsigned ROM_DW   = 16;
    localparam int unsigned SCCB_AW  = 8;
    localparam int unsigned SCCB_DW  = 8;

    // ROM word field positions, shared with the table init file
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [ROM_DW-1:0] END_CODE_DEF   = 16'hFFFF;
    localparam logic [ROM_DW-1:0] DELAY_CODE_DEF = 16'hFFF0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DELAY  = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register table ROM and issues one SCCB write per entry,
// honouring end-of-table and fixed-delay entries.
module cam_cfg_sequencer
    import cam_cfg_sequencer_pkg::*;
#(
    parameter int unsigned       ROM_AW       = 8,
    parameter int unsigned       DELAY_CYCLES = 250_000,
    parameter logic [ROM_DW-1:0] END_CODE     = END_CODE_DEF,
    parameter logic [ROM_DW-1:0] DELAY_CODE   = DELAY_CODE_DEF
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_cfg_start,
    output logic [ROM_AW-1:0]   o_rom_addr,
    input  logic [ROM_DW-1:0]   i_rom_data,
    output logic                o_sccb_valid,
    output logic [SCCB_AW-1:0]  o_sccb_addr,
    output logic [SCCB_DW-1:0]  o_sccb_data,
    input  logic                i_sccb_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ROM_AW-1:0]   o_wr_count
);

    localparam int unsigned       CNT_W     = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    seq_state_t       state;
    logic [CNT_W-1:0] dly_cnt;
    logic             last_entry_c;

    assign last_entry_c = (o_rom_addr == ADDR_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            dly_cnt      <= '0;
            o_rom_addr   <= '0;
            o_sccb_valid <= 1'b0;
            o_sccb_addr  <= '0;
            o_sccb_data  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_wr_count   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_cfg_start) begin
                        o_rom_addr <= '0;
                        o_wr_count <= '0;
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                // ROM output for the new address lands during this cycle
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (i_rom_data == END_CODE) begin
                        state <= ST_FLUSH;
                    end else if (i_rom_data == DELAY_CODE) begin
                        dly_cnt <= CNT_LOAD;
                        state   <= ST_DELAY;
                    end else begin
                        o_sccb_addr  <= i_rom_data[ADDR_MSB:ADDR_LSB];
                        o_sccb_data  <= i_rom_data[DATA_MSB:DATA_LSB];
                        o_sccb_valid <= 1'b1;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_sccb_ready) begin
                        o_sccb_valid <= 1'b0;
                        if (o_wr_count != ADDR_LAST) begin
                            o_wr_count <= o_wr_count + ROM_AW'(1);
                        end
                        if (last_entry_c) begin
                            o_err <= 1'b1;
                            state <= ST_FLUSH;
                        end else begin
                            o_rom_addr <= o_rom_addr + ROM_AW'(1);
                            state      <= ST_FETCH;
                        end
                    end
                end
                // Counter runs DELAY_CYCLES-1 down to 0: exactly DELAY_CYCLES clocks here
                ST_DELAY: begin
                    if (dly_cnt == '0) begin
                        if (last_entry_c) begin
                            o_err <= 1'b1;
                            state <= ST_FLUSH;
                        end else begin
                            o_rom_addr <= o_rom_addr + ROM_AW'(1);
                            state      <= ST_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (i_sccb_ready) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a behavioural synchronous table ROM.
module tb_cam_cfg_sequencer;

    localparam int unsigned AW  = 3;
    localparam int unsigned DLY = 16;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_cfg_start = 1'b0;
    logic          i_sccb_ready = 1'b0;
    logic [AW-1:0] o_rom_addr;
    logic [15:0]   i_rom_data = 16'h0000;
    logic          o_sccb_valid;
    logic [7:0]    o_sccb_addr;
    logic [7:0]    o_sccb_data;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW-1:0] o_wr_count;

    logic [15:0] rom [8];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } xfer_t;

    xfer_t xq[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    cam_cfg_sequencer #(
        .ROM_AW       (AW),
        .DELAY_CYCLES (DLY)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_cfg_start  (i_cfg_start),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_sccb_valid (o_sccb_valid),
        .o_sccb_addr  (o_sccb_addr),
        .o_sccb_data  (o_sccb_data),
        .i_sccb_ready (i_sccb_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_wr_count   (o_wr_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

    // Log every accepted transfer with the index of the edge it happened on
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_sccb_valid && i_sccb_ready)
            xq.push_back('{o_sccb_addr, o_sccb_data, cyc});
    end

    function automatic logic [15:0] xw(input int i);
        if (i < xq.size()) return {xq[i].a, xq[i].d};
        return 16'hxxxx;
    endfunction

    function automatic int xc(input int i);
        if (i < xq.size()) return xq[i].c;
        return -1;
    endfunction

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 8; i++) rom[i] = w;
    endtask

    task automatic basic_table();
        fill(16'h0000);
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        rom[2] = 16'hFFFF;
    endtask

    task automatic pulse_start(output int s);
        @(negedge i_clk);
        i_cfg_start = 1'b1;
        s = cyc;
        @(negedge i_clk);
        i_cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (o_done) ok = 1'b1;
            else @(negedge i_clk);
        end
        if (o_done) ok = 1'b1;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (o_sccb_valid) ok = 1'b1;
            else @(negedge i_clk);
        end
        if (o_sccb_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        vectors++;
        if ({o_sccb_valid, o_busy, o_done, o_err, o_wr_count, o_rom_addr, o_sccb_addr, o_sccb_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v%b b%b d%b e%b cnt%0d addr%0d sa%h sd%h expected all 0",
                     o_sccb_valid, o_busy, o_done, o_err, o_wr_count, o_rom_addr, o_sccb_addr, o_sccb_data);
        end
        i_rstn = 1'b1;
        repeat (3) @(negedge i_clk);
        vectors++;
        if ({o_sccb_valid, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got v%b b%b d%b expected 000", o_sccb_valid, o_busy, o_done);
        end
    endtask

    task automatic test_basic();
        int s; bit ok;
        basic_table();
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        wait_done(100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_done: got timeout expected o_done=1"); end
        vectors++;
        if (xq.size() !== 2) begin miscompares++; $display("FAIL basic_count: got %0d expected 2", xq.size()); end
        vectors++;
        if (xw(0) !== 16'h1280) begin miscompares++; $display("FAIL basic_xfer0: got %h expected 1280", xw(0)); end
        vectors++;
        if (xw(1) !== 16'h1101) begin miscompares++; $display("FAIL basic_xfer1: got %h expected 1101", xw(1)); end
        vectors++;
        if (xc(0) !== s + 3) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", xc(0) - s, 3); end
        vectors++;
        if ({o_done, o_busy, o_err, o_wr_count} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL basic_status: got d%b b%b e%b cnt%0d expected d1 b0 e0 cnt2", o_done, o_busy, o_err, o_wr_count);
        end
    endtask

    task automatic test_stall();
        int s; bit ok; bit stable;
        basic_table();
        i_sccb_ready = 1'b0;
        xq.delete();
        pulse_start(s);
        wait_valid(20, ok);
        stable = ok;
        repeat (20) begin
            @(negedge i_clk);
            if ({o_sccb_valid, o_sccb_addr, o_sccb_data} !== {1'b1, 8'h12, 8'h80}) stable = 1'b0;
        end
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL stall_hold: got v%b %h%h expected v1 1280 held", o_sccb_valid, o_sccb_addr, o_sccb_data);
        end
        vectors++;
        if (xq.size() !== 0) begin miscompares++; $display("FAIL stall_no_xfer: got %0d expected 0", xq.size()); end
        i_sccb_ready = 1'b1;
        wait_done(100, ok);
        vectors++;
        if (!ok || xq.size() !== 2 || xw(0) !== 16'h1280 || o_wr_count !== 3'd2) begin
            miscompares++;
            $display("FAIL stall_finish: got done%b n%0d first %h cnt%0d expected done1 n2 1280 cnt2",
                     ok, xq.size(), xw(0), o_wr_count);
        end
    endtask

    task automatic test_delay();
        int s; bit ok;
        fill(16'h0000);
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        wait_done(200, ok);
        vectors++;
        if (!ok || xq.size() !== 2 || o_wr_count !== 3'd2) begin
            miscompares++;
            $display("FAIL delay_run: got done%b n%0d cnt%0d expected done1 n2 cnt2", ok, xq.size(), o_wr_count);
        end
        // FETCH+DECODE+16 DELAY+FETCH+DECODE+WRITE = 21 edges between transfers
        vectors++;
        if (xc(1) - xc(0) !== 21) begin miscompares++; $display("FAIL delay_gap: got %0d expected 21", xc(1) - xc(0)); end
    endtask

    task automatic test_b2b_delay();
        int s; bit ok;
        fill(16'h0000);
        rom[0] = 16'hFFF0; rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        wait_done(200, ok);
        vectors++;
        if (!ok || xq.size() !== 1 || xw(0) !== 16'h1101) begin
            miscompares++;
            $display("FAIL b2b_delay_run: got done%b n%0d %h expected done1 n1 1101", ok, xq.size(), xw(0));
        end
        vectors++;
        if (xc(0) !== s + 39) begin miscompares++; $display("FAIL b2b_delay_time: got %0d expected 39", xc(0) - s); end
    endtask

    task automatic test_end_at_zero();
        int s; bit ok;
        fill(16'h0000);
        rom[0] = 16'hFFFF;
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        wait_done(50, ok);
        vectors++;
        if (!ok || xq.size() !== 0 || o_wr_count !== 3'd0 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL end_at_zero: got done%b n%0d cnt%0d err%b expected done1 n0 cnt0 err0",
                     ok, xq.size(), o_wr_count, o_err);
        end
    endtask

    task automatic test_overflow();
        int s; bit ok; bit seen_nz; bit wrapped; bit words_ok;
        fill(16'h0A0B);
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        ok = 1'b0; seen_nz = 1'b0; wrapped = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (o_rom_addr != '0) seen_nz = 1'b1;
            else if (seen_nz) wrapped = 1'b1;
            if (o_done) ok = 1'b1;
            else @(negedge i_clk);
        end
        words_ok = 1'b1;
        for (int i = 0; i < xq.size(); i++) if (xw(i) !== 16'h0A0B) words_ok = 1'b0;
        vectors++;
        if (!ok || xq.size() !== 8 || !words_ok) begin
            miscompares++;
            $display("FAIL overflow_xfers: got done%b n%0d words_ok%b expected done1 n8 words_ok1", ok, xq.size(), words_ok);
        end
        vectors++;
        if ({o_err, o_done, o_wr_count} !== {1'b1, 1'b1, 3'd7}) begin
            miscompares++;
            $display("FAIL overflow_status: got e%b d%b cnt%0d expected e1 d1 cnt7", o_err, o_done, o_wr_count);
        end
        vectors++;
        if (wrapped) begin miscompares++; $display("FAIL overflow_wrap: got addr returned to 0 expected no wrap"); end
    endtask

    task automatic test_back_to_back();
        int s; int s2; bit ok;
        basic_table();
        i_sccb_ready = 1'b1;
        xq.delete();
        pulse_start(s);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (o_wr_count == 3'd1) ok = 1'b1;
            else @(negedge i_clk);
        end
        i_sccb_ready = 1'b0;
        wait_valid(20, ok);
        pulse_start(s2);
        @(negedge i_clk);
        vectors++;
        if ({o_sccb_valid, o_sccb_addr, o_sccb_data, o_wr_count, o_rom_addr, o_busy} !==
            {1'b1, 8'h11, 8'h01, 3'd1, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got v%b %h%h cnt%0d addr%0d b%b expected v1 1101 cnt1 addr1 b1",
                     o_sccb_valid, o_sccb_addr, o_sccb_data, o_wr_count, o_rom_addr, o_busy);
        end
        i_sccb_ready = 1'b1;
        wait_done(100, ok);
        vectors++;
        if (!ok || xq.size() !== 2 || xw(1) !== 16'h1101 || o_wr_count !== 3'd2) begin
            miscompares++;
            $display("FAIL busy_start_run: got done%b n%0d %h cnt%0d expected done1 n2 1101 cnt2",
                     ok, xq.size(), xw(1), o_wr_count);
        end
        xq.delete();
        pulse_start(s2);
        vectors++;
        if ({o_done, o_wr_count, o_busy} !== {1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_clear: got d%b cnt%0d b%b expected d0 cnt0 b1", o_done, o_wr_count, o_busy);
        end
        wait_done(100, ok);
        vectors++;
        if (!ok || xq.size() !== 2 || xw(0) !== 16'h1280 || xw(1) !== 16'h1101 ||
            xc(0) !== s2 + 3 || o_wr_count !== 3'd2) begin
            miscompares++;
            $display("FAIL restart_repeat: got done%b n%0d %h %h lat%0d cnt%0d expected done1 n2 1280 1101 lat3 cnt2",
                     ok, xq.size(), xw(0), xw(1), xc(0) - s2, o_wr_count);
        end
    endtask

    task automatic test_reset_mid_write();
        int s; bit ok; bit quiet;
        basic_table();
        i_sccb_ready = 1'b0;
        xq.delete();
        pulse_start(s);
        wait_valid(20, ok);
        @(negedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        vectors++;
        if ({o_sccb_valid, o_busy, o_done, o_err, o_wr_count, o_rom_addr, o_sccb_addr, o_sccb_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_write: got v%b b%b d%b e%b cnt%0d addr%0d sa%h sd%h expected all 0",
                     o_sccb_valid, o_busy, o_done, o_err, o_wr_count, o_rom_addr, o_sccb_addr, o_sccb_data);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        i_sccb_ready = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge i_clk);
            if (o_sccb_valid !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet || xq.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got quiet%b n%0d expected quiet1 n0", quiet, xq.size());
        end
    endtask

    initial begin
        fill(16'h0000);
        repeat (3) @(negedge i_clk);
        test_reset();
        test_basic();
        test_stall();
        test_delay();
        test_b2b_delay();
        test_end_at_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
Walks a synchronous register-table ROM of {reg_addr, reg_data} entries and issues one SCCB register write per entry to the downstream SCCB master, using a valid/ready handshake. It is started by the single-cycle cfg_start pulse from the system-control block, which fires after reset. The table supports an end marker and a fixed-delay entry. It reports busy, done, truncated-table error and a write count for the status LEDs.

Parameters:
ROM_AW, 8, ROM address width; table depth is 2^ROM_AW entries.
DELAY_CYCLES, 250_000, clocks spent on a delay entry (10 ms at 25 MHz).
END_CODE, 16'hFFFF, ROM word that terminates the table.
DELAY_CODE, 16'hFFF0, ROM word that inserts a DELAY_CYCLES wait.

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_cfg_start  in  1  single-cycle start pulse from system control
o_rom_addr  out  ROM_AW  table ROM address
i_rom_data  in  16  ROM word {reg_addr[15:8], reg_data[7:0]}, valid 1 clock after o_rom_addr changes
o_sccb_valid  out  1  write request valid
o_sccb_addr  out  8  camera register address
o_sccb_data  out  8  camera register data
i_sccb_ready  in  1  SCCB master idle / accepts request
o_busy  out  1  sequence in progress
o_done  out  1  sequence finished, level
o_err  out  1  table ended without END_CODE
o_wr_count  out  ROM_AW  writes accepted this run

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; delay counter 0.
- States: IDLE, FETCH, DECODE, WRITE, DELAY, FLUSH, DONE.
- IDLE/DONE: on i_cfg_start=1 -> o_rom_addr=0, o_wr_count=0, o_done=0, o_err=0, o_busy=1, go to FETCH.
- FETCH: one wait cycle covering ROM latency -> DECODE.
- DECODE: decode i_rom_data.
  - END_CODE -> FLUSH.
  - DELAY_CODE -> load counter with DELAY_CYCLES-1 -> DELAY.
  - Otherwise: register o_sccb_addr/o_sccb_data from the word, o_sccb_valid=1 -> WRITE.
- WRITE: o_sccb_valid, addr and data are held stable until a cycle with i_sccb_ready=1; that is the transfer.
  - On the transfer cycle: next cycle o_sccb_valid=0 and o_wr_count+1.
  - Then advance the address and go to FETCH, or go to FLUSH if this was the last address (see boundaries).
- DELAY: decrement each clock; at 0, advance the address as in WRITE -> FETCH. The delay entry therefore costs exactly DELAY_CYCLES clocks in DELAY.
- FLUSH: wait for i_sccb_ready=1, so the last write has completed -> DONE with o_done=1, o_busy=0.
- DONE: o_done held until the next i_cfg_start.
- Latency: start pulse to first o_sccb_valid = 3 clocks (FETCH, DECODE, then valid registered).
- Boundaries:
  - i_cfg_start while o_busy=1 is ignored; no restart and no glitch on outputs.
  - Address at 2^ROM_AW-1 with no END_CODE: after that entry's transfer or delay, go to FLUSH with o_err=1. No wrap to 0.
  - END_CODE at address 0: no writes, FLUSH -> DONE, o_wr_count=0.
  - Back-to-back DELAY_CODE entries each take a full DELAY_CYCLES.
  - i_sccb_ready held low indefinitely: WRITE/FLUSH stall forever. No timeout in this block.
  - Reset mid-write: o_sccb_valid drops asynchronously. The SCCB master sees the request withdrawn and must tolerate it.
  - o_sccb_valid never deasserts before the transfer cycle.
- Widths: o_wr_count saturates at 2^ROM_AW-1. DELAY counter width = clog2(DELAY_CYCLES+1).

Decomposition:
- Shared camera package holds:
  - state encoding localparams;
  - END_CODE/DELAY_CODE;
  - the SCCB ROM word field positions (addr [15:8], data [7:0]), so the ROM init file and the ROM module agree.
- One natural sub-module: cam_cfg_rom. It is a synchronous 2^ROM_AW x 16 ROM initialised from a hex file and lives outside this block. The sequencer itself holds no sub-modules.

Test Plan:
- Table {0x1280, 0x1101, 0xFFFF}, ready always 1, start pulse -> exactly two transfers, (0x12,0x80) then (0x11,0x01); first valid 3 clocks after start; o_done=1, o_wr_count=2, o_err=0.
- Same table, ready low for 20 clocks on the first write -> valid/addr/data stable all 20 clocks, a single transfer, no duplicate.
- Table {0x1280, 0xFFF0, 0x1101, 0xFFFF}, DELAY_CYCLES=16 -> 16 DELAY clocks (plus FETCH/DECODE overhead) between the first transfer and the second valid.
- Table full of 0x0A0B entries, no END_CODE, ROM_AW=3 -> 8 transfers, then o_err=1, o_done=1, o_wr_count=7 (saturated), o_rom_addr never returns to 0 mid-run.
- Start pulse during WRITE -> ignored; then after DONE a second start -> o_done clears, o_wr_count clears, sequence repeats identically.
- Assert i_rstn=0 mid-WRITE (asynchronous, between clock edges) -> all outputs 0 immediately; after release, state IDLE and no valid until the next start.
